// File: rtl/addsub_arbiter_pkg.sv
// Shared types and constants for the two-requester add/subtract arbiter.
// Optional macro ADDSUB_OVF_EN enables the signed-overflow result path.
package addsub_arbiter_pkg;

    localparam int ADD_W = 32;

    typedef logic [0:0] state_t;
    localparam state_t IDLE = 1'b0;
    localparam state_t CALC = 1'b1;

    typedef logic req_id_t;

    // Overflow when both effective operands share a sign the result does not.
    function automatic logic calc_ovf(input logic a_msb, input logic bin_msb,
                                      input logic s_msb);
        return (a_msb == bin_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/addsub_arbiter_adder32.sv
// Shared 32-bit ripple-carry adder; subtraction is done by the caller
// inverting b and driving cin high.
module adder32
    import addsub_arbiter_pkg::*;
(
    input  logic [ADD_W-1:0] a,
    input  logic [ADD_W-1:0] b,
    input  logic             cin,
    output logic [ADD_W-1:0] s,
    output logic             cout
);

    logic carry;

    always_comb begin
        carry = cin;
        s     = '0;
        for (int i = 0; i < ADD_W; i++) begin
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sequencing two requesters onto one adder32.
// Define ADDSUB_OVF_EN to add the registered rsp*_ovf outputs.
module addsub_arbiter
    import addsub_arbiter_pkg::*;
#(
    parameter int WIDTH     = ADD_W,
    parameter int PRIO_INIT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_sub,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_sub,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_s,
    output logic             rsp0_cout,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_s,
    output logic             rsp1_cout
`ifdef ADDSUB_OVF_EN
    ,
    output logic             rsp0_ovf,
    output logic             rsp1_ovf
`endif
);

    state_t           state;
    req_id_t          ptr;
    req_id_t          lat_id;
    logic [WIDTH-1:0] lat_a;
    logic [WIDTH-1:0] lat_b;
    logic             lat_sub;

    logic [1:0]       elig;
    logic             grant;
    req_id_t          grant_id;

    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             res_cout;

    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [1:0]       rsp_cout;
    logic [WIDTH-1:0] rsp_s [2];

    // Eligibility uses the registered slot state, so a slot draining this cycle still blocks.
    always_comb begin
        elig     = {req1_valid & ~rsp_valid[1], req0_valid & ~rsp_valid[0]};
        grant    = (state == IDLE) && (elig != 2'b00);
        grant_id = (elig == 2'b11) ? ptr : elig[1];
    end

    assign req0_ready = rst_n & grant & (grant_id == 1'b0);
    assign req1_ready = rst_n & grant & (grant_id == 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= PRIO_INIT[0];
            lat_id  <= 1'b0;
            lat_a   <= '0;
            lat_b   <= '0;
            lat_sub <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        lat_id  <= grant_id;
                        lat_a   <= grant_id ? req1_a   : req0_a;
                        lat_b   <= grant_id ? req1_b   : req0_b;
                        lat_sub <= grant_id ? req1_sub : req0_sub;
                        state   <= CALC;
                    end
                end
                default: begin
                    ptr   <= ~lat_id;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bin = lat_b ^ {WIDTH{lat_sub}};

    adder32 u_adder (
        .a    (lat_a),
        .b    (bin),
        .cin  (lat_sub),
        .s    (sum),
        .cout (carry)
    );

    assign res_cout  = lat_sub ^ carry;
    assign rsp_ready = {rsp1_ready, rsp0_ready};

`ifdef ADDSUB_OVF_EN
    logic       res_ovf;
    logic [1:0] rsp_ovf;
    assign res_ovf = calc_ovf(lat_a[WIDTH-1], bin[WIDTH-1], sum[WIDTH-1]);
`endif

    // One identical response slot per requester; a fill can only target an empty slot.
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rsp_valid[gi] <= 1'b0;
                rsp_s[gi]     <= '0;
                rsp_cout[gi]  <= 1'b0;
`ifdef ADDSUB_OVF_EN
                rsp_ovf[gi]   <= 1'b0;
`endif
            end else if (state == CALC && lat_id == 1'(gi)) begin
                rsp_valid[gi] <= 1'b1;
                rsp_s[gi]     <= sum;
                rsp_cout[gi]  <= res_cout;
`ifdef ADDSUB_OVF_EN
                rsp_ovf[gi]   <= res_ovf;
`endif
            end else if (rsp_valid[gi] && rsp_ready[gi]) begin
                rsp_valid[gi] <= 1'b0;
            end
        end
    end

    assign rsp0_valid = rsp_valid[0];
    assign rsp1_valid = rsp_valid[1];
    assign rsp0_s     = rsp_s[0];
    assign rsp1_s     = rsp_s[1];
    assign rsp0_cout  = rsp_cout[0];
    assign rsp1_cout  = rsp_cout[1];
`ifdef ADDSUB_OVF_EN
    assign rsp0_ovf   = rsp_ovf[0];
    assign rsp1_ovf   = rsp_ovf[1];
`endif

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed self-checking bench for addsub_arbiter; covers ADDSUB_OVF_EN when defined.
module tb_addsub_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_sub, req1_sub;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready, rsp1_ready;
    logic [31:0] rsp0_s, rsp1_s;
    logic        rsp0_cout, rsp1_cout;
`ifdef ADDSUB_OVF_EN
    logic        rsp0_ovf, rsp1_ovf;
`endif

    int numCompared   = 0;
    int numMismatched = 0;

    always #5 clk = ~clk;

    addsub_arbiter #(.WIDTH(32), .PRIO_INIT(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sub   (req0_sub),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sub   (req1_sub),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_s     (rsp0_s),
        .rsp0_cout  (rsp0_cout),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_s     (rsp1_s),
        .rsp1_cout  (rsp1_cout)
`ifdef ADDSUB_OVF_EN
        ,
        .rsp0_ovf   (rsp0_ovf),
        .rsp1_ovf   (rsp1_ovf)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        numCompared++;
        if (observed !== expected) begin
            numMismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int port, input logic valid, input logic [31:0] a,
                                 input logic [31:0] b, input logic sub);
        if (port == 0) begin
            req0_valid = valid; req0_a = a; req0_b = b; req0_sub = sub;
        end else begin
            req1_valid = valid; req1_a = a; req1_b = b; req1_sub = sub;
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        // Both requesters offer work straight out of reset.
        applyStimulus(0, 1'b1, 32'd5, 32'd3, 1'b0);
        applyStimulus(1, 1'b1, 32'd3, 32'd5, 1'b1);
        #12;
        checkOutput("reset_req0_ready", 32'(req0_ready), 32'd0);
        checkOutput("reset_req1_ready", 32'(req1_ready), 32'd0);
        checkOutput("reset_rsp0_valid", 32'(rsp0_valid), 32'd0);
        checkOutput("reset_rsp1_valid", 32'(rsp1_valid), 32'd0);
        checkOutput("reset_rsp0_s", rsp0_s, 32'd0);
        checkOutput("reset_rsp1_cout", 32'(rsp1_cout), 32'd0);

        @(negedge clk); rst_n = 1'b1; #1;
        checkOutput("c0_req0_ready", 32'(req0_ready), 32'd1);
        checkOutput("c0_req1_ready", 32'(req1_ready), 32'd0);

        @(negedge clk); #1;
        checkOutput("c1_req0_ready", 32'(req0_ready), 32'd0);
        checkOutput("c1_req1_ready", 32'(req1_ready), 32'd0);
        checkOutput("c1_rsp0_valid", 32'(rsp0_valid), 32'd0);
        applyStimulus(0, 1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0);

        @(negedge clk); #1;
        checkOutput("add_rsp0_valid", 32'(rsp0_valid), 32'd1);
        checkOutput("add_rsp0_s", rsp0_s, 32'd8);
        checkOutput("add_rsp0_cout", 32'(rsp0_cout), 32'd0);
        checkOutput("c2_req1_ready", 32'(req1_ready), 32'd1);
        checkOutput("c2_req0_ready", 32'(req0_ready), 32'd0);

        @(negedge clk); #1;
        checkOutput("c3_req1_ready", 32'(req1_ready), 32'd0);
        checkOutput("c3_rsp0_drained", 32'(rsp0_valid), 32'd0);

        @(negedge clk); #1;
        checkOutput("sub_rsp1_valid", 32'(rsp1_valid), 32'd1);
        checkOutput("sub_rsp1_s", rsp1_s, 32'hFFFF_FFFE);
        checkOutput("sub_rsp1_cout", 32'(rsp1_cout), 32'd1);
        checkOutput("c4_req0_ready", 32'(req0_ready), 32'd1);
        checkOutput("c4_req1_ready", 32'(req1_ready), 32'd0);

        @(negedge clk); #1;
        applyStimulus(1, 1'b1, 32'd10, 32'd10, 1'b1);

        @(negedge clk); #1;
        checkOutput("wrap_rsp0_valid", 32'(rsp0_valid), 32'd1);
        checkOutput("wrap_rsp0_s", rsp0_s, 32'd0);
        checkOutput("wrap_rsp0_cout", 32'(rsp0_cout), 32'd1);
        checkOutput("c6_req1_ready", 32'(req1_ready), 32'd1);
        // Block slot 0 and queue another op on requester 0.
        rsp0_ready = 1'b0;
        applyStimulus(0, 1'b1, 32'd100, 32'd1, 1'b1);

        @(negedge clk); #1;
        checkOutput("bp_rsp0_held_valid", 32'(rsp0_valid), 32'd1);
        checkOutput("bp_rsp0_held_s", rsp0_s, 32'd0);
        applyStimulus(1, 1'b1, 32'h8000_0000, 32'd1, 1'b1);

        @(negedge clk); #1;
        checkOutput("eq_rsp1_valid", 32'(rsp1_valid), 32'd1);
        checkOutput("eq_rsp1_s", rsp1_s, 32'd0);
        checkOutput("eq_rsp1_cout", 32'(rsp1_cout), 32'd0);
        checkOutput("bp_c8_req0_ready", 32'(req0_ready), 32'd0);

        @(negedge clk); #1;
        checkOutput("bp_c9_req0_ready", 32'(req0_ready), 32'd0);
        checkOutput("bp_c9_req1_ready", 32'(req1_ready), 32'd1);

        @(negedge clk); #1;
        checkOutput("bp_c10_rsp0_valid", 32'(rsp0_valid), 32'd1);
        req1_valid = 1'b0;

        @(negedge clk); #1;
        checkOutput("bp_rsp1_s", rsp1_s, 32'h7FFF_FFFF);
        checkOutput("bp_rsp1_cout", 32'(rsp1_cout), 32'd0);
        checkOutput("bp_c11_req0_ready", 32'(req0_ready), 32'd0);
        rsp0_ready = 1'b1;

        @(negedge clk); #1;
        checkOutput("unblock_rsp0_valid", 32'(rsp0_valid), 32'd0);
        checkOutput("unblock_req0_ready", 32'(req0_ready), 32'd1);

        // Reset arrives while requester 0's op is in CALC.
        @(negedge clk); #1;
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        #1;
        checkOutput("midrst_rsp0_valid", 32'(rsp0_valid), 32'd0);
        checkOutput("midrst_rsp0_s", rsp0_s, 32'd0);
        checkOutput("midrst_rsp1_s", rsp1_s, 32'd0);
        checkOutput("midrst_req0_ready", 32'(req0_ready), 32'd0);

        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); #1;
        checkOutput("postrst1_rsp0_valid", 32'(rsp0_valid), 32'd0);
        @(negedge clk); #1;
        checkOutput("postrst2_rsp0_valid", 32'(rsp0_valid), 32'd0);
        checkOutput("postrst2_rsp1_valid", 32'(rsp1_valid), 32'd0);

        applyStimulus(0, 1'b1, 32'h7FFF_FFFF, 32'd1, 1'b0);
        #1;
        checkOutput("ovf_req0_ready", 32'(req0_ready), 32'd1);
        @(negedge clk); #1;
        req0_valid = 1'b0;
        checkOutput("ovf_c1_rsp0_valid", 32'(rsp0_valid), 32'd0);
        @(negedge clk); #1;
        checkOutput("ovf_rsp0_valid", 32'(rsp0_valid), 32'd1);
        checkOutput("ovf_rsp0_s", rsp0_s, 32'h8000_0000);
        checkOutput("ovf_rsp0_cout", 32'(rsp0_cout), 32'd0);
`ifdef ADDSUB_OVF_EN
        checkOutput("ovf_rsp0_ovf", 32'(rsp0_ovf), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule

// File: doc/addsub_arbiter.md
# addsub_arbiter

Two-requester arbiter and sequencer for the shared 32-bit ripple add/subtract unit. It accepts operations from two independent requesters over valid/ready handshakes and grants the unit round-robin. It latches operands, runs the unit for one cycle and returns each result to the originating requester through a one-deep registered response slot. It sits between the two datapath clients and the single adder32 instance they share.

## Interface
- WIDTH, 32: operand/result width; fixed by adder32, any other value is a configuration error.
- PRIO_INIT, 0: requester granted first when both are eligible after reset (0 or 1).

- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  operation offered.
- req0_ready / req1_ready  out  1  operation accepted this cycle.
- req0_a / req1_a  in  WIDTH  operand a.
- req0_b / req1_b  in  WIDTH  operand b.
- req0_sub / req1_sub  in  1  1 = a−b, 0 = a+b.
- rsp0_valid / rsp1_valid  out  1  response slot full.
- rsp0_ready / rsp1_ready  in  1  requester consumes the response.
- rsp0_s / rsp1_s  out  WIDTH  sum/difference.
- rsp0_cout / rsp1_cout  out  1  add: carry out; sub: borrow (1 iff a < b unsigned).
- rsp0_ovf / rsp1_ovf  out  1  signed overflow; present only with ADDSUB_OVF_EN.

## Operation
- FSM states: IDLE and CALC.
- Eligibility: requester i is eligible iff reqi_valid=1 and rspi_valid=0, using the registered slot state. A slot drained in the same cycle does not count as empty.
- IDLE, neither requester eligible: stay in IDLE.
- IDLE, one requester eligible: grant it.
- IDLE, both eligible: grant the one the round-robin pointer selects.
- On a grant:
  - assert reqi_ready combinationally for that cycle only;
  - latch a, b, sub and the grant id;
  - go to CALC.
- CALC:
  - drive adder32 with the latched a, b and cin=sub;
  - write s, cout (and ovf) into the granted slot and set rspi_valid;
  - toggle the pointer to the other requester;
  - return to IDLE.
- reqi_ready is never asserted in CALC. The sustained rate is one operation per 2 cycles.
- Response slot: rspi_valid clears on the cycle rspi_valid and rspi_ready are both 1. Data is held stable while valid=1 and ready=0.
- Arithmetic: results wrap modulo 2^32 with no saturation. For sub, cout is adder32's cin^carry, so it reads 1 on borrow.
- Requester inputs are don't-care unless reqi_valid=1. A requester must hold its operands stable until ready.

## Timing
- Reset (rst_n=0, asynchronous):
  - state goes to IDLE and the pointer goes to PRIO_INIT;
  - req*_ready, rsp*_valid, rsp*_s, rsp*_cout and rsp*_ovf all read 0;
  - an in-flight CALC is discarded and no response is produced.
- Latency: a handshake on edge N sets rspi_valid on edge N+2 (visible in cycle N+2).
- Back-to-back: requester 0 accepted at N, then requester 1 accepted at N+2 if eligible, with round-robin alternation under continuous load.
- A blocked slot (rspi_ready held low) stalls only requester i; the other requester keeps being served on every grant opportunity.
- Releasing reset with valid already high: the first grant can occur in the first cycle after deassertion.

## Configuration
- ADDSUB_OVF_EN defined:
  - rsp0_ovf and rsp1_ovf ports exist and are registered with the result;
  - ovf = (a[31] == bin[31]) && (s[31] != a[31]), where bin = b ^ {32{sub}}.
- ADDSUB_OVF_EN undefined: the ovf ports and the ovf logic are absent, and all other behaviour is identical.

## Structure
- Shared package holds:
  - the state typedef (IDLE, CALC);
  - ADD_W = 32;
  - the requester-id typedef (1 bit).
- One sub-module: the existing adder32 instance, driven from the latched operand registers. Its carry chain is the only combinational path in CALC.
- Response slots are two instances of identical per-requester logic, written inline or as a generate loop. They are not a separate module.

## Test plan
- Add: req0 a=5, b=3, sub=0 → rsp0_s=8, cout=0, rsp0_valid exactly 2 cycles after the handshake.
- Subtract with borrow: req1 a=3, b=5, sub=1 → rsp1_s=0xFFFFFFFE, cout=1.
- Wrap: a=0xFFFFFFFF, b=1, add → s=0, cout=1. With ADDSUB_OVF_EN, a=0x7FFFFFFF, b=1, add → ovf=1.
- Contention: both requesters valid continuously from reset with PRIO_INIT=0, both rsp_ready=1 → grants go 0,1,0,1, with one ready pulse every 2 cycles.
- Backpressure: rsp0_ready=0 with rsp0 full → req0_ready stays 0 while req1 is still accepted and answered; raising rsp0_ready frees the slot and req0 is granted next.
- Reset mid-op: assert rst_n=0 during CALC → all outputs read 0 immediately, and no response appears after release.
